// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encodings and oversampling constants,
// common to the transmitter, receiver and baud-rate tick generator.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START      = 3'd1,
        DATA       = 3'd2,
        STOP       = 3'd3,
        BREAK_WAIT = 3'd4
    } rx_state_t;

    localparam int OVERSAMPLE = 16;
    localparam int MID_START  = 7;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs; reset value selectable so idle-high
// lines come out of reset in their inactive state.
module sync_2ff #(
    parameter int   WIDTH   = 1,
    parameter logic RST_VAL = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= {WIDTH{RST_VAL}};
            q    <= {WIDTH{RST_VAL}};
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_fsm.sv
// 16x-oversampled UART receiver: start/data/stop recovery with framing-error and
// line-break reporting. Pulse outputs are registered.
//
//  state      | meaning
//  IDLE       | line idle, waiting for a low level
//  START      | timing to mid start bit, rejecting glitches
//  DATA       | sampling DBIT data bits mid-bit, LSB first
//  STOP       | timing the stop period, reporting the byte
//  BREAK_WAIT | break seen, waiting for the line to return high
module uart_rx_fsm
    import uart_pkg::*;
#(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx,
    input  logic       s_tick,
    output logic [7:0] dout,
    output logic       rx_done_tick,
    output logic       frame_err,
    output logic       break_tick
);

    // 1.5/2 stop bits need more than 16 ticks, so the counter widens only then.
    localparam int SW = (SB_TICK > OVERSAMPLE) ? 5 : 4;

    localparam logic [SW-1:0] S_MID  = SW'(MID_START);
    localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
    localparam logic [2:0]    N_LAST = 3'(DBIT - 1);

    logic            rx_s;
    rx_state_t       state_q, state_d;
    logic [SW-1:0]   s_q, s_d;
    logic [2:0]      n_q, n_d;
    logic [DBIT-1:0] b_q, b_d;
    logic [7:0]      dout_q, dout_d;
    logic            done_q, done_d;
    logic            ferr_q, ferr_d;
    logic            brk_q, brk_d;

    sync_2ff #(
        .WIDTH   (1),
        .RST_VAL (1'b1)
    ) u_sync_rx (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (rx),
        .q       (rx_s)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            dout_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
            brk_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
            brk_q   <= brk_d;
        end
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        dout_d  = dout_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;
        brk_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    s_d     = '0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_q == S_MID) begin
                        if (!rx_s) begin
                            state_d = DATA;
                            s_d     = '0;
                            n_d     = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_q == S_LAST) begin
                        s_d = '0;
                        b_d = {rx_s, b_q[DBIT-1:1]};
                        if (n_q == N_LAST) state_d = STOP;
                        else               n_d     = n_q + 3'd1;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s_q == S_STOP) begin
                        dout_d            = '0;
                        dout_d[DBIT-1:0]  = b_q;
                        done_d            = 1'b1;
                        ferr_d            = !rx_s;
                        // An all-zero frame with a low stop sample is a held-low line.
                        if (!rx_s && (b_q == '0)) begin
                            brk_d   = 1'b1;
                            state_d = BREAK_WAIT;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            BREAK_WAIT: begin
                if (rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        dout         = dout_q;
        rx_done_tick = done_q;
        frame_err    = ferr_q;
        break_tick   = brk_q;
    end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed bench for uart_rx_fsm: frame-level expectation queues checked every cycle,
// plus literal checks of the recovered bytes and flags.
module tb_uart_rx_fsm;

    localparam int CLK_PER_TICK = 4;
    localparam int BIT_CLKS     = 16 * CLK_PER_TICK;

    typedef struct packed {
        logic [7:0] d;
        logic       fe;
        logic       bk;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       s_tick = 1'b0;
    logic       rx0 = 1'b1;
    logic       rx7 = 1'b1;
    logic [7:0] dout0, dout7;
    logic       done0, fe0, bk0, done7, fe7, bk7;

    exp_t       q0[$];
    exp_t       q7[$];
    logic [7:0] model_dout0 = 8'h00;
    logic [7:0] model_dout7 = 8'h00;
    int         compared = 0;
    int         mismatched = 0;
    int         fail_prints = 0;
    int         done_cnt0 = 0;
    int         done_cnt7 = 0;
    logic [7:0] last_dout0 = 8'h00;
    logic [7:0] last_dout7 = 8'h00;
    logic       last_fe0 = 1'b0;
    logic       last_bk0 = 1'b0;

    uart_rx_fsm #(.DBIT(8), .SB_TICK(16)) u_dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .rx           (rx0),
        .s_tick       (s_tick),
        .dout         (dout0),
        .rx_done_tick (done0),
        .frame_err    (fe0),
        .break_tick   (bk0)
    );

    uart_rx_fsm #(.DBIT(7), .SB_TICK(16)) u_dut7 (
        .clk          (clk),
        .reset_n      (reset_n),
        .rx           (rx7),
        .s_tick       (s_tick),
        .dout         (dout7),
        .rx_done_tick (done7),
        .frame_err    (fe7),
        .break_tick   (bk7)
    );

    always #5 clk = ~clk;

    initial begin
        int c;
        c = 0;
        forever begin
            @(posedge clk);
            #1;
            s_tick = (c == CLK_PER_TICK - 1);
            c = (c + 1) % CLK_PER_TICK;
        end
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] expv);
        compared++;
        if (act !== expv) begin
            mismatched++;
            if (fail_prints < 40) begin
                fail_prints++;
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
            end
        end
    endtask

    // Frame-level model: what a receiver must report for a given transmitted frame.
    task automatic expect_frame(input int k, input logic [7:0] data, input int nbits,
                                input logic stop_v);
        exp_t e;
        e.d  = data & 8'((1 << nbits) - 1);
        e.fe = (stop_v == 1'b0);
        e.bk = e.fe && (e.d == 8'h00);
        if (k == 0) q0.push_back(e);
        else        q7.push_back(e);
    endtask

    task automatic check_inst(input int k, input logic [7:0] d, input logic done,
                              input logic fe, input logic bk);
        exp_t       e;
        logic [7:0] md;
        bit         empty;
        md    = (k == 0) ? model_dout0 : model_dout7;
        empty = (k == 0) ? (q0.size() == 0) : (q7.size() == 0);
        if (!reset_n) begin
            cmp("reset_dout", 32'(d), 32'h0);
            cmp("reset_done", 32'(done), 32'h0);
            cmp("reset_ferr", 32'(fe), 32'h0);
            cmp("reset_brk",  32'(bk), 32'h0);
            if (k == 0) model_dout0 = 8'h00;
            else        model_dout7 = 8'h00;
        end else if (done) begin
            if (empty) begin
                cmp("unexpected_done", 32'(done), 32'h0);
            end else begin
                if (k == 0) e = q0.pop_front();
                else        e = q7.pop_front();
                cmp("frame_dout", 32'(d), 32'(e.d));
                cmp("frame_ferr", 32'(fe), 32'(e.fe));
                cmp("frame_brk",  32'(bk), 32'(e.bk));
                if (k == 0) begin
                    model_dout0 = e.d;
                    done_cnt0++;
                    last_dout0 = d;
                    last_fe0   = fe;
                    last_bk0   = bk;
                end else begin
                    model_dout7 = e.d;
                    done_cnt7++;
                    last_dout7 = d;
                end
            end
        end else begin
            cmp("dout_hold",  32'(d), 32'(md));
            cmp("ferr_alone", 32'(fe), 32'h0);
            cmp("brk_alone",  32'(bk), 32'h0);
        end
    endtask

    always @(negedge clk) begin
        check_inst(0, dout0, done0, fe0, bk0);
        check_inst(7, dout7, done7, fe7, bk7);
    end

    task automatic drive(input int k, input logic v, input int clks);
        if (k == 0) rx0 = v;
        else        rx7 = v;
        repeat (clks) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int k, input logic [7:0] data, input int nbits,
                              input logic stop_v, input int stop_clks);
        drive(k, 1'b0, BIT_CLKS);
        for (int i = 0; i < nbits; i++) drive(k, data[i], BIT_CLKS);
        drive(k, stop_v, stop_clks);
        if (k == 0) rx0 = 1'b1;
        else        rx7 = 1'b1;
    endtask

    task automatic wait_drain(input int k, input int budget);
        bit empty;
        for (int i = 0; i < budget; i++) begin
            empty = (k == 0) ? (q0.size() == 0) : (q7.size() == 0);
            if (empty) break;
            @(posedge clk);
        end
        #1;
        empty = (k == 0) ? (q0.size() == 0) : (q7.size() == 0);
        cmp("drain_timeout", 32'(empty), 32'h1);
        if (k == 0) q0.delete();
        else        q7.delete();
    endtask

    initial begin
        int c0;
        repeat (5) @(posedge clk);
        #1;
        reset_n = 1'b1;
        drive(0, 1'b1, 20);

        c0 = done_cnt0;
        expect_frame(0, 8'h55, 8, 1'b1);
        send_frame(0, 8'h55, 8, 1'b1, BIT_CLKS);
        drive(0, 1'b1, BIT_CLKS);
        wait_drain(0, 300);
        cmp("lit_55_dout", 32'(last_dout0), 32'h55);
        cmp("lit_55_count", 32'(done_cnt0 - c0), 32'd1);
        cmp("lit_55_ferr", 32'(last_fe0), 32'h0);
        cmp("lit_55_brk", 32'(last_bk0), 32'h0);

        c0 = done_cnt0;
        expect_frame(0, 8'hA3, 8, 1'b1);
        expect_frame(0, 8'h0F, 8, 1'b1);
        send_frame(0, 8'hA3, 8, 1'b1, BIT_CLKS);
        send_frame(0, 8'h0F, 8, 1'b1, BIT_CLKS);
        drive(0, 1'b1, BIT_CLKS);
        wait_drain(0, 300);
        cmp("lit_b2b_count", 32'(done_cnt0 - c0), 32'd2);
        cmp("lit_b2b_dout", 32'(last_dout0), 32'h0F);

        c0 = done_cnt0;
        drive(0, 1'b0, 3 * CLK_PER_TICK);
        drive(0, 1'b1, 300);
        cmp("lit_glitch_count", 32'(done_cnt0 - c0), 32'd0);
        cmp("lit_glitch_dout", 32'(dout0), 32'h0F);

        // Stop held low only past its mid-point so the tail cannot pass a start check.
        c0 = done_cnt0;
        expect_frame(0, 8'h81, 8, 1'b0);
        send_frame(0, 8'h81, 8, 1'b0, 48);
        drive(0, 1'b1, 2 * BIT_CLKS);
        wait_drain(0, 300);
        cmp("lit_81_dout", 32'(last_dout0), 32'h81);
        cmp("lit_81_ferr", 32'(last_fe0), 32'h1);
        cmp("lit_81_brk", 32'(last_bk0), 32'h0);
        cmp("lit_81_count", 32'(done_cnt0 - c0), 32'd1);

        c0 = done_cnt0;
        expect_frame(0, 8'h00, 8, 1'b0);
        send_frame(0, 8'h00, 8, 1'b0, 11 * BIT_CLKS);
        drive(0, 1'b1, 200);
        wait_drain(0, 100);
        cmp("lit_brk_count", 32'(done_cnt0 - c0), 32'd1);
        cmp("lit_brk_dout", 32'(last_dout0), 32'h00);
        cmp("lit_brk_ferr", 32'(last_fe0), 32'h1);
        cmp("lit_brk_brk", 32'(last_bk0), 32'h1);
        expect_frame(0, 8'h3C, 8, 1'b1);
        send_frame(0, 8'h3C, 8, 1'b1, BIT_CLKS);
        drive(0, 1'b1, BIT_CLKS);
        wait_drain(0, 300);
        cmp("lit_3c_dout", 32'(last_dout0), 32'h3C);

        drive(0, 1'b0, BIT_CLKS);
        drive(0, 1'b1, 100);
        reset_n = 1'b0;
        drive(0, 1'b1, 8);
        cmp("lit_rst_dout", 32'(dout0), 32'h00);
        reset_n = 1'b1;
        drive(0, 1'b1, 8 * BIT_CLKS);
        c0 = done_cnt0;
        expect_frame(0, 8'h12, 8, 1'b1);
        send_frame(0, 8'h12, 8, 1'b1, BIT_CLKS);
        drive(0, 1'b1, BIT_CLKS);
        wait_drain(0, 300);
        cmp("lit_12_count", 32'(done_cnt0 - c0), 32'd1);
        cmp("lit_12_dout", 32'(last_dout0), 32'h12);

        c0 = done_cnt7;
        expect_frame(7, 8'h45, 7, 1'b1);
        send_frame(7, 8'h45, 7, 1'b1, BIT_CLKS);
        drive(7, 1'b1, BIT_CLKS);
        wait_drain(7, 300);
        cmp("lit_d7_count", 32'(done_cnt7 - c0), 32'd1);
        cmp("lit_d7_dout", 32'(last_dout7), 32'h45);
        cmp("lit_d7_bit7", 32'(last_dout7[7]), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
